// File: rtl/rgb_to_luma_pipe.sv
// Three-stage RGB-to-luma converter with per-pixel mode/coefficients, frame sideband
// and an output pixel counter. A single global stall holds every stage when the output is blocked.
module rgb_to_luma_pipe #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_red,
    input  logic [DATA_W-1:0] in_green,
    input  logic [DATA_W-1:0] in_blue,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [1:0]        mode,
    input  logic [COEF_W-1:0] coef_r,
    input  logic [COEF_W-1:0] coef_g,
    input  logic [COEF_W-1:0] coef_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_luma,
    output logic              out_sof,
    output logic              out_eol,
    output logic [31:0]       pix_cnt
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = DATA_W + COEF_W + 2;
    localparam int RND_W  = SUM_W + 1;
    localparam int SH     = (COEF_W > 8) ? COEF_W - 8 : 0;

    generate
        if (COEF_W < 8) begin : g_coef_w_check
            $error("rgb_to_luma_pipe: COEF_W must be at least 8");
        end
    endgenerate

    // Fixed coefficient sets are defined on an 8-bit scale and shifted up for wider COEF_W.
    localparam logic [COEF_W-1:0] K601_R = COEF_W'(77)  << SH;
    localparam logic [COEF_W-1:0] K601_G = COEF_W'(150) << SH;
    localparam logic [COEF_W-1:0] K601_B = COEF_W'(29)  << SH;
    localparam logic [COEF_W-1:0] K709_R = COEF_W'(54)  << SH;
    localparam logic [COEF_W-1:0] K709_G = COEF_W'(183) << SH;
    localparam logic [COEF_W-1:0] K709_B = COEF_W'(19)  << SH;
    localparam logic [COEF_W-1:0] KAVG_R = COEF_W'(85)  << SH;
    localparam logic [COEF_W-1:0] KAVG_G = COEF_W'(86)  << SH;
    localparam logic [COEF_W-1:0] KAVG_B = COEF_W'(85)  << SH;

    localparam logic [RND_W-1:0] HALF  = RND_W'(1) << (COEF_W - 1);
    localparam logic [RND_W-1:0] LIMIT = RND_W'({DATA_W{1'b1}});

    logic              advance;
    logic [COEF_W-1:0] cr, cg, cb;

    logic              s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0] s1_pr_q, s1_pr_d, s1_pg_q, s1_pg_d, s1_pb_q, s1_pb_d;
    logic              s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;

    logic              s2_valid_q, s2_valid_d;
    logic [SUM_W-1:0]  s2_sum_q, s2_sum_d;
    logic              s2_sof_q, s2_sof_d, s2_eol_q, s2_eol_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_luma_q, out_luma_d;
    logic              out_sof_q, out_sof_d, out_eol_q, out_eol_d;
    logic [31:0]       pix_cnt_q, pix_cnt_d;

    logic [RND_W-1:0]  rounded;
    logic [DATA_W-1:0] luma_sat;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        cr = K601_R;
        cg = K601_G;
        cb = K601_B;
        case (mode)
            2'd1: begin cr = K709_R; cg = K709_G; cb = K709_B; end
            2'd2: begin cr = KAVG_R; cg = KAVG_G; cb = KAVG_B; end
            2'd3: begin cr = coef_r; cg = coef_g; cb = coef_b; end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pr_d    = s1_pr_q;
        s1_pg_d    = s1_pg_q;
        s1_pb_d    = s1_pb_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_pr_d    = PROD_W'(in_red)   * PROD_W'(cr);
            s1_pg_d    = PROD_W'(in_green) * PROD_W'(cg);
            s1_pb_d    = PROD_W'(in_blue)  * PROD_W'(cb);
            s1_sof_d   = in_sof;
            s1_eol_d   = in_eol;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_sof_d   = s2_sof_q;
        s2_eol_d   = s2_eol_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            s2_sum_d   = SUM_W'(s1_pr_q) + SUM_W'(s1_pg_q) + SUM_W'(s1_pb_q);
            s2_sof_d   = s1_sof_q;
            s2_eol_d   = s1_eol_q;
        end
    end

    // Round half-up, then clamp; only custom coefficients can exceed full scale.
    always_comb begin
        rounded  = (RND_W'(s2_sum_q) + HALF) >> COEF_W;
        luma_sat = (rounded > LIMIT) ? {DATA_W{1'b1}} : rounded[DATA_W-1:0];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_luma_d  = out_luma_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        pix_cnt_d   = pix_cnt_q;
        if (advance) begin
            out_valid_d = s2_valid_q;
            out_luma_d  = s2_valid_q ? luma_sat : '0;
            out_sof_d   = s2_valid_q & s2_sof_q;
            out_eol_d   = s2_valid_q & s2_eol_q;
        end
        if (out_valid_q && out_ready) begin
            pix_cnt_d = out_sof_q ? 32'd1 : pix_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_luma_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            pix_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_luma_q  <= out_luma_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    // Intermediate data and sideband are qualified by their valids, so they need no reset.
    always_ff @(posedge clk) begin
        s1_pr_q  <= s1_pr_d;
        s1_pg_q  <= s1_pg_d;
        s1_pb_q  <= s1_pb_d;
        s1_sof_q <= s1_sof_d;
        s1_eol_q <= s1_eol_d;
        s2_sum_q <= s2_sum_d;
        s2_sof_q <= s2_sof_d;
        s2_eol_q <= s2_eol_d;
    end

    assign out_valid = out_valid_q;
    assign out_luma  = out_luma_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_rgb_to_luma_pipe.sv
// Directed bench for rgb_to_luma_pipe: fixed vectors with hand-derived luma values,
// stall burst with an expected queue, frame counter and mid-stream reset.
module tb_rgb_to_luma_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_red, in_green, in_blue;
    logic        in_sof, in_eol;
    logic [1:0]  mode;
    logic [7:0]  coef_r, coef_g, coef_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_luma;
    logic        out_sof, out_eol;
    logic [31:0] pix_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] r, g, b;
        logic [1:0] m;
        logic [7:0] cr, cg, cb;
        logic [7:0] y;
    } vec_t;

    always #5 clk = ~clk;

    rgb_to_luma_pipe #(.DATA_W(8), .COEF_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_sof(in_sof), .in_eol(in_eol), .mode(mode),
        .coef_r(coef_r), .coef_g(coef_g), .coef_b(coef_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_luma(out_luma), .out_sof(out_sof), .out_eol(out_eol),
        .pix_cnt(pix_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic drive_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                             input logic [1:0] m, input logic sof, input logic eol);
        in_valid = 1'b1;
        in_red   = r;
        in_green = g;
        in_blue  = b;
        mode     = m;
        in_sof   = sof;
        in_eol   = eol;
    endtask

    // One pixel through an empty pipe; returns what is visible 3 cycles after its transfer.
    task automatic push_and_wait(input vec_t v, output logic vld, output logic [7:0] y);
        coef_r = v.cr;
        coef_g = v.cg;
        coef_b = v.cb;
        drive_pix(v.r, v.g, v.b, v.m, 1'b0, 1'b0);
        step();
        idle();
        coef_r = 8'd0;
        coef_g = 8'd0;
        coef_b = 8'd0;
        step();
        step();
        vld = out_valid;
        y   = out_luma;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        out_ready = 1'b1;
        mode = 2'd0;
        in_red = 8'd0; in_green = 8'd0; in_blue = 8'd0;
        coef_r = 8'd0; coef_g = 8'd0; coef_b = 8'd0;
        repeat (3) step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (out_luma !== 8'd0) begin n_bad++; $display("FAIL reset_out_luma: got %0d expected 0", out_luma); end
        n_cmp++; if (out_sof !== 1'b0 || out_eol !== 1'b0) begin n_bad++; $display("FAIL reset_sideband: got sof=%0b eol=%0b expected 0/0", out_sof, out_eol); end
        n_cmp++; if (pix_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_pix_cnt: got %0d expected 0", pix_cnt); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_bt601_latency();
        drive_pix(8'd255, 8'd255, 8'd255, 2'd0, 1'b0, 1'b0);
        step();
        drive_pix(8'd100, 8'd50, 8'd25, 2'd0, 1'b0, 1'b0);
        step();
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bt601_early_valid: got %0b expected 0 at cycle 2", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_luma !== 8'd255) begin n_bad++; $display("FAIL bt601_white: got v=%0b y=%0d expected v=1 y=255", out_valid, out_luma); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_luma !== 8'd62) begin n_bad++; $display("FAIL bt601_mixed: got v=%0b y=%0d expected v=1 y=62", out_valid, out_luma); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_luma !== 8'd0) begin n_bad++; $display("FAIL bt601_drain_zero: got v=%0b y=%0d expected v=0 y=0", out_valid, out_luma); end
    endtask

    task automatic test_modes();
        vec_t vecs[9];
        logic       vld;
        logic [7:0] y;
        vecs[0] = '{r:8'd0,   g:8'd255, b:8'd0,   m:2'd1, cr:8'd0,   cg:8'd0,   cb:8'd0,   y:8'd182};
        vecs[1] = '{r:8'd30,  g:8'd60,  b:8'd90,  m:2'd2, cr:8'd0,   cg:8'd0,   cb:8'd0,   y:8'd60};
        vecs[2] = '{r:8'd255, g:8'd255, b:8'd255, m:2'd3, cr:8'd255, cg:8'd255, cb:8'd255, y:8'd255};
        vecs[3] = '{r:8'd255, g:8'd255, b:8'd255, m:2'd3, cr:8'd0,   cg:8'd0,   cb:8'd0,   y:8'd0};
        vecs[4] = '{r:8'd1,   g:8'd0,   b:8'd0,   m:2'd3, cr:8'd128, cg:8'd0,   cb:8'd0,   y:8'd1};
        vecs[5] = '{r:8'd3,   g:8'd0,   b:8'd0,   m:2'd3, cr:8'd128, cg:8'd0,   cb:8'd0,   y:8'd2};
        vecs[6] = '{r:8'd127, g:8'd0,   b:8'd0,   m:2'd3, cr:8'd1,   cg:8'd0,   cb:8'd0,   y:8'd0};
        vecs[7] = '{r:8'd255, g:8'd1,   b:8'd0,   m:2'd3, cr:8'd255, cg:8'd200, cb:8'd0,   y:8'd255};
        vecs[8] = '{r:8'd1,   g:8'd1,   b:8'd0,   m:2'd3, cr:8'd255, cg:8'd255, cb:8'd255, y:8'd2};
        for (int i = 0; i < 9; i++) begin
            push_and_wait(vecs[i], vld, y);
            n_cmp++;
            if (vld !== 1'b1 || y !== vecs[i].y) begin
                n_bad++;
                $display("FAIL mode_vec%0d: got v=%0b y=%0d expected v=1 y=%0d", i, vld, y, vecs[i].y);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_pix(8'd100, 8'd50, 8'd25, 2'd0, 1'b0, 1'b0);
        step();
        drive_pix(8'd100, 8'd50, 8'd25, 2'd1, 1'b0, 1'b0);
        step();
        drive_pix(8'd100, 8'd50, 8'd25, 2'd2, 1'b0, 1'b0);
        step();
        idle();
        n_cmp++; if (out_valid !== 1'b1 || out_luma !== 8'd62) begin n_bad++; $display("FAIL b2b_mode0: got v=%0b y=%0d expected v=1 y=62", out_valid, out_luma); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_luma !== 8'd59) begin n_bad++; $display("FAIL b2b_mode1: got v=%0b y=%0d expected v=1 y=59", out_valid, out_luma); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_luma !== 8'd58) begin n_bad++; $display("FAIL b2b_mode2: got v=%0b y=%0d expected v=1 y=58", out_valid, out_luma); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got v=%0b expected 0", out_valid); end
    endtask

    // Gray pixels in average mode come out unchanged, so each expected luma is the input value.
    task automatic test_stall();
        int idx = 0;
        int got = 0;
        int cyc = 0;
        logic [7:0] v;
        logic [9:0] e;
        exp_q.delete();
        while ((idx < 20 || got < 20) && cyc < 200) begin
            out_ready = !(cyc >= 8 && cyc < 13);
            v = 8'(idx * 11 + 5);
            if (idx < 20) drive_pix(v, v, v, 2'd2, idx == 0, idx == 9 || idx == 19);
            else idle();
            #1;
            if (!out_ready && out_valid) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %0b expected 0 at cyc %0d", in_ready, cyc); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_sof, in_eol, v});
                idx++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_extra_out: got y=%0d expected no output", out_luma);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sof, out_eol, out_luma} !== e) begin
                        n_bad++;
                        $display("FAIL stall_out%0d: got sof=%0b eol=%0b y=%0d expected sof=%0b eol=%0b y=%0d",
                                 got, out_sof, out_eol, out_luma, e[9], e[8], e[7:0]);
                    end
                end
                got++;
            end
            step();
            cyc++;
        end
        idle();
        out_ready = 1'b1;
        n_cmp++;
        if (got != 20 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_count: got %0d outputs, %0d pending expected 20 outputs, 0 pending", got, exp_q.size());
        end
        step();
        step();
        step();
    endtask

    task automatic test_frames();
        int idx = 0;
        int k = 0;
        int cyc = 0;
        logic xfer;
        logic sof_seen;
        logic [7:0] v;
        out_ready = 1'b1;
        while (k < 14 && cyc < 100) begin
            v = 8'(idx * 3 + 1);
            if (idx < 14) drive_pix(v, v, v, 2'd2, (idx % 7) == 0, (idx % 7) == 6);
            else idle();
            #1;
            if (in_valid && in_ready) idx++;
            xfer     = out_valid && out_ready;
            sof_seen = out_sof;
            step();
            if (xfer) begin
                n_cmp++;
                if (pix_cnt !== 32'((k % 7) + 1) || sof_seen !== ((k % 7) == 0)) begin
                    n_bad++;
                    $display("FAIL frame_cnt%0d: got cnt=%0d sof=%0b expected cnt=%0d sof=%0b",
                             k, pix_cnt, sof_seen, (k % 7) + 1, (k % 7) == 0);
                end
                k++;
            end
            cyc++;
        end
        idle();
        n_cmp++;
        if (k != 14) begin n_bad++; $display("FAIL frame_total: got %0d transfers expected 14", k); end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive_pix(8'd255, 8'd255, 8'd255, 2'd0, 1'b1, 1'b0);
        step();
        drive_pix(8'd100, 8'd50, 8'd25, 2'd0, 1'b0, 1'b0);
        step();
        drive_pix(8'd30, 8'd60, 8'd90, 2'd2, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        n_cmp++; if (pix_cnt !== 32'd0) begin n_bad++; $display("FAIL rstmid_pix_cnt: got %0d expected 0", pix_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %0b expected 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_flushed%0d: got v=%0b y=%0d expected v=0", i, out_valid, out_luma); end
            step();
        end
        drive_pix(8'd100, 8'd50, 8'd25, 2'd0, 1'b0, 1'b0);
        step();
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_c1: got v=%0b expected 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_c2: got v=%0b expected 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_luma !== 8'd62) begin n_bad++; $display("FAIL rstmid_c3: got v=%0b y=%0d expected v=1 y=62", out_valid, out_luma); end
        step();
    endtask

    initial begin
        test_reset();
        test_bt601_latency();
        test_modes();
        test_back_to_back();
        test_stall();
        test_frames();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rgb_to_luma_pipe.md
RGB_TO_LUMA_PIPE -- requirements
Module: rgb_to_luma_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning per-channel and output sample width.
REQ-002 SHALL have parameter COEF_W, default 8, meaning unsigned coefficient width and number of fraction bits.
REQ-003 SHALL have port clk, input, 1, the clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input pixel is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the input pixel this cycle.
REQ-007 SHALL have ports in_red, in_green and in_blue, input, DATA_W each, meaning the pixel channels.
REQ-008 SHALL have ports in_sof and in_eol, input, 1 each, meaning start-of-frame and end-of-line sideband.
REQ-009 SHALL have port mode, input, 2, meaning the conversion mode, sampled with each accepted pixel.
REQ-010 SHALL have ports coef_r, coef_g and coef_b, input, COEF_W each, meaning the custom coefficients, sampled with each accepted pixel.
REQ-011 SHALL have ports out_valid and out_ready, output and input, 1 each, meaning the output handshake.
REQ-012 SHALL have port out_luma, output, DATA_W, meaning the grayscale result.
REQ-013 SHALL have ports out_sof and out_eol, output, 1 each, meaning the sideband aligned to out_luma.
REQ-014 SHALL have port pix_cnt, output, 32, meaning output transfers since the last out_sof transfer, inclusive.

Function
REQ-015 Transfer SHALL occur when valid && ready on the same side; in_valid is not required to depend on in_ready.
REQ-016 The pipeline SHALL be three stages: S1 registers the products; S2 registers the sum; S3 rounds and saturates into the output register.
REQ-017 Latency SHALL be exactly 3 cycles from the input transfer to out_valid when out_ready stays high.
REQ-018 Throughput SHALL be one pixel per cycle with no bubbles while out_ready=1.
REQ-019 Stall: advance = !out_valid || out_ready; when advance=0, every stage SHALL hold its data, valid and sideband.
REQ-020 in_ready SHALL equal advance, as a combinational function of out_valid and out_ready only.
REQ-021 Coefficient set (r,g,b) for a COEF_W=8 scale: mode 0 = 77,150,29 (BT.601); mode 1 = 54,183,19 (BT.709); mode 2 = 85,86,85 (average); mode 3 = coef_r,coef_g,coef_b.
REQ-022 For COEF_W other than 8, fixed coefficients SHALL be scaled by a left shift of (COEF_W-8), and COEF_W < 8 SHALL be rejected at elaboration.
REQ-023 Sum SHALL be r*cr + g*cg + b*cb, held at DATA_W+COEF_W+2 bits with no overflow.
REQ-024 out_luma SHALL be (sum + 2^(COEF_W-1)) >> COEF_W, i.e. round-half-up.
REQ-025 out_luma SHALL saturate to 2^DATA_W-1 when the rounded value exceeds that limit (possible in mode 3 only).
REQ-026 Mode and coefficients SHALL travel with the pixel, so a mode change mid-stream affects only pixels accepted after the change.
REQ-027 in_sof and in_eol SHALL be delayed identically to the data and SHALL never be dropped or duplicated under stall.
REQ-028 pix_cnt SHALL load 1 on an output transfer with out_sof=1, SHALL increment on any other output transfer, and SHALL wrap at 2^32.
REQ-029 While out_valid=0, out_luma, out_sof and out_eol SHALL be driven to 0.

Reset
REQ-030 While rst=1, all stage valids, out_valid, out_luma, out_sof, out_eol and pix_cnt SHALL be 0 on the next edge.
REQ-031 Reset mid-stream SHALL discard all in-flight pixels without emitting them.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.
REQ-033 Stage data registers other than the output register MAY be left unreset.

Verification
REQ-034 Mode 0, pixel (255,255,255) then (100,50,25), out_ready=1 -> out_luma 255 then 62, on cycles 3 and 4 after the first transfer.
REQ-035 Mode 1, (0,255,0) -> 182; mode 2, (30,60,90) -> 60.
REQ-036 Mode 3, coefficients 255/255/255, pixel (255,255,255) -> 255 (saturated); coefficients 0/0/0 -> 0.
REQ-037 Continuous input of 20 pixels with out_ready held low for 5 cycles mid-burst -> in_ready low during the hold, and all 20 outputs in order with none lost or duplicated, sideband aligned.
REQ-038 Two frames where in_sof is set on pixel 0 of each, 7 pixels each -> pix_cnt 1..7, then back to 1 on the second out_sof.
REQ-039 rst asserted for 1 cycle with 3 pixels in flight -> no out_valid for those pixels, pix_cnt=0, and the next input produces output 3 cycles later.
